// File: rtl/result_collector_pkg.sv
// Shared definitions for the result collector: drain FSM state encodings
// and a constant-evaluable ceiling-log2 used to size addresses and counters.
package result_collector_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_DRAIN = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned rem;
    result = 0;
    rem    = (value > 0) ? value - 1 : 0;
    while (rem != 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/result_collector_if.sv
// Bus between the systolic array / result memory and the collector.
//   D        : PE results, PE[x][y] at slice x*N+y
//   valid_D  : one-cycle per-PE result strobes
//   wr_*     : result memory write request with ready backpressure
//   done     : all tiles written
//   overrun  : sticky capture error
// master = collector side, slave = array/memory side.
interface result_collector_if
  import result_collector_pkg::*;
#(
  parameter int unsigned D_W_ACC = 16,
  parameter int unsigned N       = 4,
  parameter int unsigned M       = 8
) ();

  localparam int unsigned ADDR_W = clog2(M * M);

  logic [D_W_ACC*N*N-1:0] D;
  logic [N*N-1:0]         valid_D;
  logic                   wr_en;
  logic                   wr_ready;
  logic [ADDR_W-1:0]      wr_addr;
  logic [D_W_ACC-1:0]     wr_data;
  logic                   done;
  logic                   overrun;

  modport master (
    input  D, valid_D, wr_ready,
    output wr_en, wr_addr, wr_data, done, overrun
  );

  modport slave (
    output D, valid_D, wr_ready,
    input  wr_en, wr_addr, wr_data, done, overrun
  );

endinterface

// File: rtl/result_collector_tile_capture.sv
// Capture buffer: one register plus filled flag per PE.
//   i_d / i_valid : PE results and strobes
//   i_enable      : accept strobes at all (low once every tile is written)
//   i_clear       : tile handed to the drain buffer this edge
//   o_data        : captured words
//   o_full        : registered "all slots filled"
//   o_overrun     : sticky, set when a strobe hits an already filled slot
module tile_capture #(
  parameter int unsigned D_W_ACC = 16,
  parameter int unsigned NN      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [D_W_ACC*NN-1:0]   i_d,
  input  logic [NN-1:0]           i_valid,
  input  logic                    i_enable,
  input  logic                    i_clear,
  output logic [D_W_ACC-1:0]      o_data [NN],
  output logic                    o_full,
  output logic                    o_overrun
);

  logic [NN-1:0]      r_filled;
  logic [D_W_ACC-1:0] r_data [NN];
  logic               r_full;
  logic               r_overrun;
  logic [NN-1:0]      w_take;
  logic [NN-1:0]      w_clash;

  // A clear frees every slot, so a strobe on the clearing edge never clashes.
  always_comb begin
    w_take  = i_enable ? i_valid : '0;
    w_clash = i_clear ? '0 : (w_take & r_filled);
  end

  // Slot storage, fill flags, full and overrun registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_filled  <= '0;
      r_full    <= 1'b0;
      r_overrun <= 1'b0;
      for (int i = 0; i < int'(NN); i++) r_data[i] <= '0;
    end else begin
      r_filled <= (i_clear ? '0 : r_filled) | w_take;
      r_full   <= i_clear ? 1'b0 : &r_filled;
      if (|w_clash) r_overrun <= 1'b1;
      for (int i = 0; i < int'(NN); i++) begin
        if (w_take[i] && (i_clear || !r_filled[i]))
          r_data[i] <= i_d[i*D_W_ACC +: D_W_ACC];
      end
    end
  end

  assign o_data    = r_data;
  assign o_full    = r_full;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/result_collector.sv
// Collects N x N PE results per tile and writes them out as M*M/(N*N)
// consecutive tiles of N*N words to the result memory.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : result_collector_if master (PE results in, memory writes out)
module result_collector
  import result_collector_pkg::*;
#(
  parameter int unsigned D_W_ACC = 16,
  parameter int unsigned N       = 4,
  parameter int unsigned M       = 8
) (
  input  logic                clk,
  input  logic                rst,
  result_collector_if.master  bus
);

  localparam int unsigned NN     = N * N;
  localparam int unsigned TILES  = (M * M) / NN;
  localparam int unsigned ADDR_W = clog2(M * M);
  localparam int unsigned K_W    = (clog2(NN) > 0) ? clog2(NN) : 1;
  localparam int unsigned TILE_W = clog2(TILES) + 1;

  logic [D_W_ACC-1:0] w_cap_data [NN];
  logic               w_cap_full;
  logic               w_overrun;
  logic               w_xfer;

  state_t             r_state, w_state_nxt;
  logic [K_W-1:0]     r_k, w_k_nxt, w_k_inc;
  logic [TILE_W-1:0]  r_tile, w_tile_nxt;
  logic [D_W_ACC-1:0] r_drain [NN];
  logic               r_wr_en, w_wr_en_nxt;
  logic [ADDR_W-1:0]  r_wr_addr, w_wr_addr_nxt;
  logic [D_W_ACC-1:0] r_wr_data, w_wr_data_nxt;
  logic               r_done, w_done_nxt;

  tile_capture #(
    .D_W_ACC (D_W_ACC),
    .NN      (NN)
  ) u_capture (
    .clk       (clk),
    .rst       (rst),
    .i_d       (bus.D),
    .i_valid   (bus.valid_D),
    .i_enable  (r_state != ST_DONE),
    .i_clear   (w_xfer),
    .o_data    (w_cap_data),
    .o_full    (w_cap_full),
    .o_overrun (w_overrun)
  );

  // Next-state and next-output logic; the write port is preloaded one word
  // ahead so an accepted beat can be followed by the next one immediately.
  always_comb begin
    w_state_nxt   = r_state;
    w_k_nxt       = r_k;
    w_k_inc       = r_k + 1'b1;
    w_tile_nxt    = r_tile;
    w_wr_en_nxt   = r_wr_en;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    w_done_nxt    = r_done;
    w_xfer        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cap_full) begin
          w_xfer        = 1'b1;
          w_state_nxt   = ST_DRAIN;
          w_k_nxt       = '0;
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = ADDR_W'(32'(r_tile) * NN);
          w_wr_data_nxt = w_cap_data[0];
        end
      end
      ST_DRAIN: begin
        if (r_wr_en && bus.wr_ready) begin
          if (r_k == K_W'(NN - 1)) begin
            w_wr_en_nxt = 1'b0;
            w_k_nxt     = '0;
            w_tile_nxt  = r_tile + 1'b1;
            if (r_tile == TILE_W'(TILES - 1)) begin
              w_state_nxt = ST_DONE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_k_nxt       = w_k_inc;
            w_wr_addr_nxt = r_wr_addr + 1'b1;
            w_wr_data_nxt = r_drain[w_k_inc];
          end
        end
      end
      ST_DONE: begin
        w_wr_en_nxt = 1'b0;
        w_done_nxt  = 1'b1;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_wr_en_nxt = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_k       <= '0;
      r_tile    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_k       <= w_k_nxt;
      r_tile    <= w_tile_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Drain buffer snapshot, taken on the transfer edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NN); i++) r_drain[i] <= '0;
    end else if (w_xfer) begin
      r_drain <= w_cap_data;
    end
  end

  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;
  assign bus.done    = r_done;
  assign bus.overrun = w_overrun;

endmodule

// File: tb/tb_result_collector.sv
// Self-checking bench for result_collector (N=4, M=8, D_W_ACC=16).
`timescale 1ns/1ps
module tb_result_collector;
  import result_collector_pkg::*;

  localparam int unsigned DW    = 16;
  localparam int unsigned N     = 4;
  localparam int unsigned M     = 8;
  localparam int unsigned NN    = N * N;
  localparam int unsigned AW    = clog2(M * M);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    int            base;
    int            rdy_mode;
    logic [DW-1:0] exp_first;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  result_collector_if #(.D_W_ACC(DW), .N(N), .M(M)) bus ();

  result_collector #(.D_W_ACC(DW), .N(N), .M(M)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wr_t  sb [$];
  int   checks   = 0;
  int   failures = 0;
  int   rdy_mode = 0;
  int   hi_cnt   = 0;
  int   wr_cnt [M*M];
  vec_t vecs [4];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Pops the scoreboard on every accepted write; checks stall stability.
  task automatic monitor();
    logic          stall = 1'b0;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_data;
    wr_t           e;
    forever begin
      @(negedge clk);
      if (stall) begin
        check("stall_wr_en", bus.wr_en, 1);
        check("stall_addr", bus.wr_addr, s_addr);
        check("stall_data", bus.wr_data, s_data);
      end
      stall  = rst && bus.wr_en && !bus.wr_ready;
      s_addr = bus.wr_addr;
      s_data = bus.wr_data;
      if (bus.wr_en) hi_cnt++;
      if (bus.wr_en && bus.wr_ready) begin
        wr_cnt[bus.wr_addr]++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write addr=%0d data=%0d", bus.wr_addr, bus.wr_data);
        end else begin
          e = sb.pop_front();
          check("wr_addr", bus.wr_addr, e.addr);
          check("wr_data", bus.wr_data, e.data);
        end
      end
    end
  endtask

  // Ready pattern: 0 = always 1, 1 = repeating 1,0,0,1, 2 = random.
  task automatic ready_drv();
    int p = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: begin
          bus.wr_ready = ((p % 4) == 0) || ((p % 4) == 3);
          p++;
        end
        2:       bus.wr_ready = 1'($urandom_range(0, 1));
        default: bus.wr_ready = 1'b1;
      endcase
    end
  endtask

  task automatic push_tile(input int tile, input int base);
    for (int k = 0; k < int'(NN); k++)
      sb.push_back('{addr: AW'(tile * NN + k), data: DW'(base + 100 * (k / N) + (k % N))});
  endtask

  // Skewed strobes: PE[x][y] pulses in cycle x+y with D = base + 100x + y.
  task automatic drive_tile(input int base, input logic [NN-1:0] mask);
    logic [DW*NN-1:0] d;
    logic [NN-1:0]    v;
    for (int c = 0; c <= 2 * (int'(N) - 1); c++) begin
      @(negedge clk);
      d = '0;
      v = '0;
      for (int x = 0; x < int'(N); x++)
        for (int y = 0; y < int'(N); y++)
          if (x + y == c && mask[x*N+y]) begin
            v[x*N+y]            = 1'b1;
            d[(x*N+y)*DW +: DW] = DW'(base + 100 * x + y);
          end
      bus.D       = d;
      bus.valid_D = v;
    end
    @(negedge clk);
    bus.valid_D = '0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || bus.wr_en) && n < 600) begin
      @(negedge clk);
      n++;
    end
    check(name, longint'(sb.size() == 0 && !bus.wr_en), 1);
  endtask

  task automatic do_reset();
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int               lat;
    int               n;
    int               bad;
    logic [DW*NN-1:0] d;
    logic [NN-1:0]    m;

    rst          = 1'b1;
    bus.D        = '0;
    bus.valid_D  = '0;
    bus.wr_ready = 1'b1;
    for (int a = 0; a < int'(M * M); a++) wr_cnt[a] = 0;
    #1 rst = 1'b0;
    fork
      monitor();
      ready_drv();
    join_none

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_done", bus.done, 0);
    check("rst_overrun", bus.overrun, 0);
    rst = 1'b1;

    // Single skewed tile, D = 100x+y, first write two cycles after PE[3][3]
    push_tile(0, 0);
    drive_tile(0, '1);
    lat = 1;
    while (!bus.wr_en && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("first_wr_latency", lat, 3);
    wait_drain("tileA_drain");

    // Four tiles back-to-back with varied ready patterns
    do_reset();
    for (int a = 0; a < int'(M * M); a++) wr_cnt[a] = 0;
    vecs[0] = '{base: 0,    rdy_mode: 0, exp_first: 16'd0};
    vecs[1] = '{base: 1000, rdy_mode: 1, exp_first: 16'd1000};
    vecs[2] = '{base: 2000, rdy_mode: 2, exp_first: 16'd2000};
    vecs[3] = '{base: 3000, rdy_mode: 1, exp_first: 16'd3000};
    for (int t = 0; t < 4; t++) begin
      rdy_mode = vecs[t].rdy_mode;
      push_tile(t, vecs[t].base);
      drive_tile(vecs[t].base, '1);
      n = 0;
      while (!(bus.wr_en && bus.wr_addr == AW'(t * NN)) && n < 400) begin
        @(negedge clk);
        n++;
      end
      check("tbl_first_seen", longint'(n < 400), 1);
      check("tbl_first_data", bus.wr_data, vecs[t].exp_first);
      check("tbl_done_low", bus.done, 0);
    end
    wait_drain("tbl_drain");
    rdy_mode = 0;
    check("done_after_63", bus.done, 1);
    check("tbl_overrun", bus.overrun, 0);
    bad = 0;
    for (int a = 0; a < int'(M * M); a++) if (wr_cnt[a] != 1) bad++;
    check("addr_written_once", bad, 0);

    // Strobes after done are ignored
    hi_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      bus.D       = {NN{16'h55AA}};
      bus.valid_D = '1;
      @(negedge clk);
      bus.valid_D = '0;
    end
    repeat (20) @(negedge clk);
    check("done_no_wr", hi_cnt, 0);
    check("done_overrun", bus.overrun, 0);
    check("done_hold", bus.done, 1);

    // Double strobe on slot 5: first value kept, overrun raised
    do_reset();
    for (int k = 0; k < int'(NN); k++)
      sb.push_back('{addr: AW'(k), data: (k == 5) ? DW'(555) : DW'(100 * (k / N) + (k % N))});
    @(negedge clk);
    d = '0;
    d[5*DW +: DW] = DW'(555);
    bus.D = d;
    bus.valid_D = NN'(1) << 5;
    @(negedge clk);
    bus.valid_D = '0;
    @(negedge clk);
    check("overrun_after_first", bus.overrun, 0);
    d[5*DW +: DW] = DW'(777);
    bus.D = d;
    bus.valid_D = NN'(1) << 5;
    @(negedge clk);
    bus.valid_D = '0;
    @(negedge clk);
    check("overrun_set", bus.overrun, 1);
    m = '1;
    m[5] = 1'b0;
    drive_tile(0, m);
    wait_drain("overrun_drain");
    check("overrun_sticky", bus.overrun, 1);

    // Reset while presenting k=7
    do_reset();
    check("rst_clears_overrun", bus.overrun, 0);
    push_tile(0, 0);
    drive_tile(0, '1);
    n = 0;
    while (!(bus.wr_en && bus.wr_addr == AW'(7)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_k7", longint'(n < 100), 1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_wr_en", bus.wr_en, 0);
    check("rst_mid_addr", bus.wr_addr, 0);
    check("rst_mid_remaining", sb.size(), 8);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    push_tile(0, 4000);
    drive_tile(4000, '1);
    wait_drain("after_rst_drain");
    check("after_rst_done", bus.done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 SHALL have parameter D_W_ACC, default 16, PE accumulator/result width.
REQ-002 SHALL have parameter N, default 4, systolic array dimension (N x N PEs).
REQ-003 SHALL have parameter M, default 8, matrix dimension; M divisible by N; TILES = (M*M)/(N*N).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port D  input  D_W_ACC*N*N  PE results; PE[x][y] at slice index x*N+y.
REQ-007 SHALL have port valid_D  input  N*N  one-cycle per-PE result strobe, bit x*N+y.
REQ-008 SHALL have port wr_en  output  1  result write request.
REQ-009 SHALL have port wr_ready  input  1  sink accepts write when wr_en && wr_ready.
REQ-010 SHALL have port wr_addr  output  clog2(M*M)  result memory word address.
REQ-011 SHALL have port wr_data  output  D_W_ACC  result word.
REQ-012 SHALL have port done  output  1  all TILES written; held until reset.
REQ-013 SHALL have port overrun  output  1  sticky error flag.

Function
REQ-014 SHALL hold a capture buffer of N*N result registers, each with a filled flag.
REQ-015 SHALL, on valid_D[i] high with slot i empty, store D slice i and set filled[i].
REQ-016 SHALL, on valid_D[i] high with slot i already filled, discard the value and set overrun.
REQ-017 SHALL register capture_full when all N*N filled flags are set.
REQ-018 SHALL hold a drain buffer of N*N words plus tile index; states IDLE, DRAIN, DONE.
REQ-019 SHALL, in IDLE with capture_full set, copy capture to drain, clear all filled flags, enter DRAIN on the same edge.
REQ-020 SHALL accept a new valid_D into the capture buffer on the same edge it is cleared by transfer (new slot value wins).
REQ-021 SHALL, in DRAIN, assert wr_en with element k = 0..N*N-1 in order, wr_data = drain[k], wr_addr = tile_idx*N*N + k.
REQ-022 SHALL advance k only on wr_en && wr_ready; wr_addr/wr_data stable while stalled.
REQ-023 SHALL, on acceptance of k = N*N-1, increment tile_idx; go to DONE if tile_idx was TILES-1, else IDLE.
REQ-024 SHALL, in DONE, hold wr_en low, done high, and ignore valid_D (no capture, no overrun).
REQ-025 SHALL produce first wr_en two cycles after the edge sampling the last missing valid (one to register full, one to transfer), drain idle and wr_ready high.
REQ-026 SHALL sustain N*N writes in N*N consecutive cycles when wr_ready is held high.
REQ-027 SHALL size tile_idx at clog2(TILES)+1 bits; no address wrap within a run.

Reset
REQ-028 SHALL, on rst low, asynchronously clear: filled flags, capture_full, k, tile_idx, state=IDLE, wr_en=0, wr_addr=0, wr_data=0, done=0, overrun=0.
REQ-029 SHALL discard any partially captured or partially drained tile on reset mid-operation; next tile after release writes from address 0.

Structure
REQ-030 SHALL take clog2 and the state enum (IDLE, DRAIN, DONE) from a shared package.
REQ-031 SHALL use one sub-module, tile_capture, holding capture registers, filled flags and overrun detection.

Verification
REQ-032 SHALL cover: skewed valids (PE[x][y] at cycle x+y), D = 100*x+y, wr_ready=1 -> 16 writes addr 0..15, data 0,1,2,3,100..303, first wr_en 2 cycles after PE[3][3] valid.
REQ-033 SHALL cover: 4 tiles back-to-back, M=8, N=4 -> addresses 0..63 each written once, done high after address 63 accepted.
REQ-034 SHALL cover: wr_ready toggled 1,0,0,1 during drain -> no duplicated or skipped address, data stable while stalled.
REQ-035 SHALL cover: valid_D[5] pulsed twice before tile complete -> overrun=1, first value written at addr 5.
REQ-036 SHALL cover: rst low during drain at k=7 -> wr_en=0 immediately, next full tile writes addresses 0..15.
REQ-037 SHALL cover: valid_D pulses after done -> no wr_en, overrun stays 0.
